// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake plus serial line and status for the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data bits, parity and stop bits, fed by a valid/ready
// handshake. The serial line is registered and follows the next state, so tx=0 appears the
// cycle after acceptance.
module uart_tx_cfg #(
  parameter int unsigned SYS_CLK_HZ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_tx_cfg_if.slave  bus
);

  localparam int unsigned DIV  = SYS_CLK_HZ / BAUD_RATE;
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BaudLast = CntW'(DIV - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $fatal(1, "uart_tx_cfg: SYS_CLK_HZ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_chk_parity
    $fatal(1, "uart_tx_cfg: PARITY must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid) begin
          state_d = StStart;
          shreg_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ (PARITY == 1);
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (STOP_BITS == 1 || stop_q) begin
            stop_d  = 1'b0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is derived from the next state so tx stays a clean flop output.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four frame formats at DIV=10, back-to-back streaming,
// mid-frame input changes and asynchronous reset during a frame.
module tb_uart_tx_cfg;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_d ();

  uart_tx_cfg #(.SYS_CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1)) u_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_a.slave));
  uart_tx_cfg #(.SYS_CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(2)) u_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_b.slave));
  uart_tx_cfg #(.SYS_CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(2)) u_c (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_c.slave));
  uart_tx_cfg #(.SYS_CLK_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(1)) u_d (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_d.slave));

  logic [3:0] tx_vec, rdy_vec, busy_vec, done_vec;
  assign tx_vec   = {if_d.tx, if_c.tx, if_b.tx, if_a.tx};
  assign rdy_vec  = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
  assign busy_vec = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign done_vec = {if_d.tx_done, if_c.tx_done, if_b.tx_done, if_a.tx_done};

  task automatic set_in(input int sel, input logic [8:0] d, input logic v);
    case (sel)
      0: begin if_a.tx_data = d[7:0]; if_a.tx_valid = v; end
      1: begin if_b.tx_data = d[7:0]; if_b.tx_valid = v; end
      2: begin if_c.tx_data = d[7:0]; if_c.tx_valid = v; end
      default: begin if_d.tx_data = d[6:0]; if_d.tx_valid = v; end
    endcase
  endtask

  // Sends one word and checks every cycle of the frame against exp (LSB = start bit).
  task automatic run_frame(input int sel, input logic [8:0] d, input int nbits,
                           input logic [15:0] exp, input bit disturb, input string name);
    int bad, cyc, hs_bad, early, extra;
    logic got;
    cyc = 0; hs_bad = 0; early = 0; extra = 0;
    @(negedge sys_clk);
    n_checks++;
    if (rdy_vec[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_idle: got %b want 1", name, rdy_vec[sel]);
    end
    set_in(sel, d, 1'b1);
    @(posedge sys_clk);
    #1 set_in(sel, d, 1'b0);
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      got = exp[b];
      for (int c = 0; c < 10; c++) begin
        @(negedge sys_clk);
        cyc++;
        if (tx_vec[sel] !== exp[b]) begin
          if (bad == 0) got = tx_vec[sel];
          bad++;
        end
        if (rdy_vec[sel] !== 1'b0 || busy_vec[sel] !== 1'b1) hs_bad++;
        if (done_vec[sel] !== 1'b0) early++;
        if (disturb) begin
          if (cyc >= 25 && cyc <= 27) set_in(sel, 9'h1FF, 1'b1);
          else if (cyc == 28) set_in(sel, 9'h1FF, 1'b0);
        end
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_bit%0d: tx got %b want %b (%0d bad cycles)", name, b, got, exp[b],
                 bad);
      end
    end
    n_checks++;
    if (hs_bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy_ready: got %0d bad cycles want 0", name, hs_bad);
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL %s_done_early: got %0d done cycles want 0", name, early);
    end
    @(negedge sys_clk);
    n_checks++;
    if (done_vec[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_pulse: got %b want 1", name, done_vec[sel]);
    end
    n_checks++;
    if (rdy_vec[sel] !== 1'b1 || tx_vec[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle_after: ready/tx got %b%b want 11", name, rdy_vec[sel], tx_vec[sel]);
    end
    @(negedge sys_clk);
    n_checks++;
    if (done_vec[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_width: got %b want 0", name, done_vec[sel]);
    end
    if (disturb) begin
      repeat (30) begin
        @(negedge sys_clk);
        if (tx_vec[sel] !== 1'b1 || busy_vec[sel] !== 1'b0) extra++;
      end
      n_checks++;
      if (extra != 0) begin
        n_fail++;
        $display("FAIL %s_no_extra_frame: got %0d active cycles want 0", name, extra);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int s = 0; s < 4; s++) set_in(s, 9'h000, 1'b0);
    repeat (3) @(negedge sys_clk);
    for (int ph = 0; ph < 2; ph++) begin
      n_checks++;
      if (tx_vec !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_tx_ph%0d: got %b want 1111", ph, tx_vec);
      end
      n_checks++;
      if (rdy_vec !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_ready_ph%0d: got %b want 1111", ph, rdy_vec);
      end
      n_checks++;
      if (busy_vec !== 4'h0 || done_vec !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_busy_done_ph%0d: got %b/%b want 0000/0000", ph, busy_vec, done_vec);
      end
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
    end
  endtask

  task automatic test_frames();
    run_frame(0, 9'h0A5, 10, 16'h034A, 1'b0, "a5_8n1");
    run_frame(1, 9'h0A5, 12, 16'h0D4A, 1'b0, "a5_8e2");
    run_frame(2, 9'h0A5, 12, 16'h0F4A, 1'b0, "a5_8o2");
    run_frame(3, 9'h07F, 10, 16'h02FE, 1'b0, "7f_7o1");
    run_frame(3, 9'h000, 10, 16'h0300, 1'b0, "00_7o1");
  endtask

  task automatic test_back_to_back();
    bit          hist [450];
    logic [7:0]  w [3];
    logic [7:0]  rx [4];
    int          acc_cyc [3];
    int          starts [4];
    int          acc, n_st, i, s, stop_bad;
    bit          acc_now;
    w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF;
    acc = 0; n_st = 0; stop_bad = 0;
    for (int k = 0; k < 4; k++) begin rx[k] = '0; starts[k] = 0; end
    for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
    @(negedge sys_clk);
    set_in(0, {1'b0, w[0]}, 1'b1);
    for (int c = 0; c < 450; c++) begin
      if (c != 0) @(negedge sys_clk);
      hist[c] = tx_vec[0];
      acc_now = rdy_vec[0] && if_a.tx_valid;
      if (acc_now && acc < 3) begin acc_cyc[acc] = c; acc++; end
      @(posedge sys_clk);
      #1;
      if (acc_now) begin
        if (acc < 3) set_in(0, {1'b0, w[acc]}, 1'b1);
        else set_in(0, 9'h000, 1'b0);
      end
    end
    i = 1;
    while (i < 450) begin
      if (hist[i-1] == 1'b1 && hist[i] == 1'b0) begin
        s = i;
        if (n_st < 4) starts[n_st] = s;
        if (s + 95 < 450 && n_st < 4) begin
          for (int k = 0; k < 8; k++) rx[n_st][k] = hist[s + 10 * (k + 1) + 4];
          if (hist[s + 94] != 1'b1) stop_bad++;
        end
        n_st++;
        i = s + 100;
      end else begin
        i++;
      end
    end
    n_checks++;
    if (acc != 3) begin
      n_fail++;
      $display("FAIL b2b_accept_count: got %0d want 3", acc);
    end
    n_checks++;
    if (n_st != 3) begin
      n_fail++;
      $display("FAIL b2b_frame_count: got %0d want 3", n_st);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (starts[k+1] - starts[k] != 101) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d want 101", k, starts[k+1] - starts[k]);
      end
    end
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] != 101) begin
      n_fail++;
      $display("FAIL b2b_accept_spacing: got %0d want 101", acc_cyc[1] - acc_cyc[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rx[k] !== w[k]) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %h want %h", k, rx[k], w[k]);
      end
    end
    n_checks++;
    if (stop_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_stop_bits: got %0d bad want 0", stop_bad);
    end
  endtask

  task automatic test_midframe();
    run_frame(0, 9'h05A, 10, 16'h02B4, 1'b1, "5a_midframe");
  endtask

  task automatic test_reset_midframe();
    @(negedge sys_clk);
    set_in(0, 9'h096, 1'b1);
    @(posedge sys_clk);
    #1 set_in(0, 9'h000, 1'b0);
    repeat (45) @(negedge sys_clk);
    // 0x96 data bit 3 is 0, so the reset visibly lifts the line.
    n_checks++;
    if (busy_vec[0] !== 1'b1 || tx_vec[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_before: busy/tx got %b%b want 10", busy_vec[0], tx_vec[0]);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_vec[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_tx: got %b want 1", tx_vec[0]);
    end
    n_checks++;
    if (rdy_vec[0] !== 1'b1 || busy_vec[0] !== 1'b0 || done_vec[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_status: ready/busy/done got %b%b%b want 100", rdy_vec[0],
               busy_vec[0], done_vec[0]);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_frame(0, 9'h03C, 10, 16'h0278, 1'b0, "3c_post_reset");
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_midframe();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks,
             n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that serialises one parallel word per frame onto `tx`. Frame format is configurable: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits. Words enter through a valid/ready handshake, so an upstream FIFO or image-pixel streamer can feed it back-to-back without dropping data. It sits at the serial output of the RS-232 path and replaces the fixed 8N1 transmitter.

Parameters:
SYS_CLK_HZ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; DIV = SYS_CLK_HZ/BAUD_RATE (integer division), clocks per bit
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  word to send, sampled only on acceptance
tx_valid  input  1  upstream holds a word
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  high from the cycle after acceptance until the end of the last stop bit
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, active-low): tx=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0. An assertion mid-frame aborts the frame immediately, with tx forced to 1; no partial-frame completion.
- Elaboration checks: DIV >= 2; DATA_BITS in 5..9; PARITY in 0..2; STOP_BITS in 1..2. Any violation is a fatal error.
- Baud counter width = clog2(DIV). It counts 0..DIV-1 in every non-IDLE state, wraps to 0, and is held at 0 in IDLE.
- Every bit lasts exactly DIV clocks.
- Acceptance: tx_valid & tx_ready on a rising edge. tx_data is latched into a shift register, and parity is computed from the latched word. Parity bit = XOR of the data bits (even); XOR inverted (odd).
- States:
  - IDLE: tx=1, tx_ready=1, busy=0. On acceptance → START.
  - START: tx=0 for DIV clocks → DATA.
  - DATA: tx = shift-register LSB. Shift right at each bit end. After DATA_BITS bits → PARITY if PARITY != 0, else → STOP.
  - PARITY: tx = parity bit for DIV clocks → STOP.
  - STOP: tx=1 for STOP_BITS*DIV clocks → IDLE.
- Outputs outside IDLE: tx_ready=0 and busy=1 in START, DATA, PARITY and STOP.
- Latency: tx falls on the first clock edge after the accepting edge, i.e. tx=0 is visible in the cycle after acceptance.
- tx_done is high for exactly one cycle: the first IDLE cycle after STOP.
- Back-to-back: a word can be accepted in that same first IDLE cycle. Minimum frame-to-frame spacing is therefore (1+DATA_BITS+P+STOP_BITS)*DIV + 1 clocks, where P = 1 if parity is enabled. The extra idle-high cycle is legal (it only lengthens the stop time).
- tx_valid outside IDLE is ignored, and tx_data changes during a frame have no effect. Upstream must hold tx_valid until tx_ready is seen; dropping tx_valid before that is legal and nothing is sent.
- The bit counter counts 0..DATA_BITS-1 and is cleared on leaving DATA; STOP uses a separate 1-bit stop counter.

Test Plan:
- SYS_CLK_HZ=1000000, BAUD_RATE=100000 (DIV=10), 8N1; send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 clocks; tx_done pulses at clock 101 after acceptance.
- Same clocking, DATA_BITS=8, PARITY=2, STOP_BITS=2; send 0xA5 → parity bit 0, two stop bits, frame 120 clocks. Repeat with PARITY=1 → parity bit 1.
- DATA_BITS=7, PARITY=1; send 0x7F → seven 1s then parity bit 0; 0x00 → parity bit 1.
- tx_valid held high with 3 words 0x01, 0x80, 0xFF → each accepted on the tx_done cycle; start bits exactly 101 clocks apart (8N1, DIV=10); no word lost or repeated.
- Change tx_data and pulse tx_valid mid-frame → frame bits unchanged, tx_ready stays 0, nothing extra sent.
- Assert sys_rst_n low during DATA bit 3 → tx=1, tx_ready=1, busy=0 asynchronously; after release, a new word 0x3C is sent as a clean full frame.
